// File: rtl/uart_pkg.sv
// Shared constants and FSM encodings for the UART receiver.
// Build option: define UART_RX_PARITY_EN to add the PARITY state (8E1/8O1 frames).
package uart_pkg;

   localparam int unsigned BAUD_DIV_DEFAULT = 868;  // 100 MHz / 115200

   localparam int unsigned ERR_PAR = 8;
   localparam int unsigned ERR_FRM = 9;

   localparam logic [7:0] CR = 8'h0D;
   localparam logic [7:0] LF = 8'h0A;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
      ST_PARITY = 3'd3,
`endif
      ST_STOP   = 3'd4,
      ST_BREAK  = 3'd5
   } state_e;

endpackage

// File: rtl/uart_baud_cnt.sv
// Loadable bit-period countdown: tick is high in the last cycle of a loaded
// interval (half or full BAUD_DIV), then the counter parks at zero unless reloaded.
module uart_baud_cnt
   import uart_pkg::*;
#(
   parameter int unsigned BAUD_DIV = BAUD_DIV_DEFAULT
) (
   input  logic CLK,
   input  logic RST,
   input  logic load_half,
   input  logic load_full,
   output logic tick
);

   localparam int unsigned CW = 12;
   localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2);
   localparam logic [CW-1:0] FULL = CW'(BAUD_DIV);

   logic [CW-1:0] cnt_q, cnt_d;

   // A load of N makes tick fire exactly N cycles after the loading cycle.
   assign tick = (cnt_q == CW'(1));

   always_comb begin
      cnt_d = cnt_q;
      if (load_half) begin
         cnt_d = HALF;
      end else if (load_full) begin
         cnt_d = FULL;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_rx_stp.sv
// UART receiver, 8 data bits LSB first, one stop bit, mid-bit sampling.
// Build option: UART_RX_PARITY_EN adds a parity bit and reports errors in RX_DATA_R[8].
module uart_rx_stp
   import uart_pkg::*;
#(
   parameter int unsigned BAUD_DIV   = BAUD_DIV_DEFAULT,
   parameter int unsigned PARITY_ODD = 0
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       RXD,
   output logic       RX_DATA_EN,
   output logic [9:0] RX_DATA_R
);

   // ---------------------------------------------------------------
   // Line synchronizer and falling-edge detect
   // ---------------------------------------------------------------
   logic       sync1_q, sync1_d;
   logic       sync2_q, sync2_d;
   logic [1:0] fill_q, fill_d;
   logic       rxs_prev_q, rxs_prev_d;
   logic       rxs;
   logic       fall;

   assign rxs = sync2_q;

   // The edge history is held low until the synchronizer has flushed its reset
   // value, so a line that is already low at release cannot look like a start edge.
   always_comb begin
      sync1_d    = RXD;
      sync2_d    = sync1_q;
      fill_d     = {fill_q[0], 1'b1};
      rxs_prev_d = rxs & fill_q[1];
   end

   assign fall = rxs_prev_q & ~rxs;

   // NOTE: synchronizer stages reset to 1 (idle line), not 0, so reset never fakes a start bit.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         sync1_q    <= 1'b1;
         sync2_q    <= 1'b1;
         fill_q     <= '0;
         rxs_prev_q <= 1'b0;
      end else begin
         sync1_q    <= sync1_d;
         sync2_q    <= sync2_d;
         fill_q     <= fill_d;
         rxs_prev_q <= rxs_prev_d;
      end
   end

   // ---------------------------------------------------------------
   // Bit timing
   // ---------------------------------------------------------------
   logic load_half;
   logic load_full;
   logic tick;

   uart_baud_cnt #(
      .BAUD_DIV (BAUD_DIV)
   ) u_baud_cnt (
      .CLK       (CLK),
      .RST       (RST),
      .load_half (load_half),
      .load_full (load_full),
      .tick      (tick)
   );

   // ---------------------------------------------------------------
   // Frame FSM
   // ---------------------------------------------------------------
   state_e     state_q, state_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [7:0] shift_q, shift_d;
   logic       data_en_q, data_en_d;
   logic [9:0] data_r_q, data_r_d;
`ifdef UART_RX_PARITY_EN
   logic       par_err_q, par_err_d;
`else
   logic       unused_parity_odd;
   assign unused_parity_odd = 1'(PARITY_ODD);
`endif

   // NOTE: every combinational output gets a default first; no branch can leave a latch.
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      data_en_d = 1'b0;
      data_r_d  = data_r_q;
      load_half = 1'b0;
      load_full = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_d = par_err_q;
`endif

      unique case (state_q)
         ST_IDLE: begin
            if (fall) begin
               state_d   = ST_START;
               bit_cnt_d = '0;
               load_half = 1'b1;
            end
         end

         ST_START: begin
            if (tick) begin
               if (rxs) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d   = ST_DATA;
                  load_full = 1'b1;
               end
            end
         end

         ST_DATA: begin
            if (tick) begin
               shift_d   = {rxs, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               load_full = 1'b1;
               if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  state_d = ST_PARITY;
`else
                  state_d = ST_STOP;
`endif
               end
            end
         end

`ifdef UART_RX_PARITY_EN
         ST_PARITY: begin
            if (tick) begin
               par_err_d = ((^shift_q) ^ rxs) != 1'(PARITY_ODD);
               load_full = 1'b1;
               state_d   = ST_STOP;
            end
         end
`endif

         ST_STOP: begin
            if (tick) begin
               data_en_d          = 1'b1;
               data_r_d[7:0]      = shift_q;
               data_r_d[ERR_FRM]  = ~rxs;
`ifdef UART_RX_PARITY_EN
               data_r_d[ERR_PAR]  = par_err_q;
`else
               data_r_d[ERR_PAR]  = 1'b0;
`endif
               state_d            = rxs ? ST_IDLE : ST_BREAK;
            end
         end

         ST_BREAK: begin
            if (rxs) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q   <= ST_IDLE;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         data_en_q <= 1'b0;
         data_r_q  <= '0;
`ifdef UART_RX_PARITY_EN
         par_err_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         data_en_q <= data_en_d;
         data_r_q  <= data_r_d;
`ifdef UART_RX_PARITY_EN
         par_err_q <= par_err_d;
`endif
      end
   end

   assign RX_DATA_EN = data_en_q;
   assign RX_DATA_R  = data_r_q;

endmodule

// File: tb/tb_uart_rx_stp.sv
// Directed bench for uart_rx_stp at BAUD_DIV=16: frames are driven bit by bit,
// expected words and pulse cycles go to a scoreboard popped on every RX_DATA_EN.
module tb_uart_rx_stp;
   import uart_pkg::*;

   localparam int B      = 16;
   localparam int H      = B / 2;
   localparam bit PAR_OD = 1'b0;
`ifdef UART_RX_PARITY_EN
   localparam int NBITS  = 11;
`else
   localparam int NBITS  = 10;
`endif
   // RXD edge -> 2 sync stages -> edge-detect cycle; stop sample BAUD/2 + (NBITS-1)*BAUD later; +1 output cycle.
   localparam int LAT    = 2 + H + (NBITS - 1) * B + 1;

   typedef struct {
      logic [9:0] val;
      int         cyc;
   } exp_t;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       RXD = 1'b1;
   logic       RX_DATA_EN;
   logic [9:0] RX_DATA_R;

   int   checks    = 0;
   int   errors    = 0;
   int   cyc       = 0;
   int   pulses    = 0;
   int   hold_viol = 0;
   exp_t sb[$];
   int   pulse_q[$];
   exp_t e;
   logic [9:0] held = '0;
   logic       prev_en = 1'b0;

   uart_rx_stp #(
      .BAUD_DIV   (B),
      .PARITY_ODD (0)
   ) dut (
      .CLK        (CLK),
      .RST        (RST),
      .RXD        (RXD),
      .RX_DATA_EN (RX_DATA_EN),
      .RX_DATA_R  (RX_DATA_R)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard consumer and hold/one-cycle-pulse watcher.
   always @(negedge CLK) begin
      if (RX_DATA_EN) begin
         pulses++;
         pulse_q.push_back(cyc);
         check("pulse_expected", 32'(sb.size() != 0), 32'd1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check("rx_data_r", 32'(RX_DATA_R), 32'(e.val));
            check("pulse_cycle", cyc, e.cyc);
         end
         if (prev_en) hold_viol++;
         held = RX_DATA_R;
      end else if (RST) begin
         held = RX_DATA_R;
      end else if (RX_DATA_R !== held) begin
         hold_viol++;
      end
      prev_en = RX_DATA_EN;
   end

   task automatic idle(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic drive_bit(input logic b);
      RXD = b;
      idle(B);
   endtask

   function automatic logic good_par(input logic [7:0] d);
      return (^d) ^ PAR_OD;
   endfunction

   // Drives one complete frame; the caller pushes the expectation (or not).
   task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                             input logic push, input logic [9:0] exp_val);
      if (push) sb.push_back('{val: exp_val, cyc: cyc + LAT});
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
      drive_bit(par);
`else
      if (par) begin end
`endif
      drive_bit(stop);
   endtask

   initial begin
      int p0;
      int n;
      logic [7:0] r;

      // Reset state
      idle(3);
      check("reset_en", 32'(RX_DATA_EN), 32'd0);
      check("reset_data", 32'(RX_DATA_R), 32'h000);
      check("reset_state", 32'(dut.state_q), 32'(ST_IDLE));
      RST = 1'b0;
      idle(4);

      // Clean 8N1 frame 0x41
      p0 = pulses;
      send_frame(8'h41, good_par(8'h41), 1'b1, 1'b1, 10'h041);
      idle(2 * B);
      check("frame41_pulses", pulses - p0, 1);

      // Glitch: 4 low cycles is a false start
      p0 = pulses;
      RXD = 1'b0;
      idle(4);
      RXD = 1'b1;
      idle(2 * B);
      check("glitch_no_pulse", pulses - p0, 0);
      check("glitch_state", 32'(dut.state_q), 32'(ST_IDLE));

      // Stop bit 0 then line held low: one framing-error word, then BREAK
      p0 = pulses;
      send_frame(8'h35, good_par(8'h35), 1'b0, 1'b1, 10'h235);
      idle(40 * B);
      check("break_one_pulse", pulses - p0, 1);
      check("break_state", 32'(dut.state_q), 32'(ST_BREAK));
      RXD = 1'b1;
      idle(2 * B);
      check("break_exit_state", 32'(dut.state_q), 32'(ST_IDLE));
      send_frame(8'h5A, good_par(8'h5A), 1'b1, 1'b1, 10'h05A);
      idle(2 * B);

      // Parity sense (even): 0x07 has odd weight
`ifdef UART_RX_PARITY_EN
      send_frame(8'h07, 1'b0, 1'b1, 1'b1, 10'h107);
      idle(B);
      send_frame(8'h07, 1'b1, 1'b1, 1'b1, 10'h007);
      idle(B);
`else
      send_frame(8'h07, 1'b0, 1'b1, 1'b1, 10'h007);
      idle(B);
`endif

      // Back-to-back CR, LF with no idle gap
      p0 = pulses;
      send_frame(CR, good_par(CR), 1'b1, 1'b1, 10'h00D);
      send_frame(LF, good_par(LF), 1'b1, 1'b1, 10'h00A);
      idle(2 * B);
      check("b2b_pulses", pulses - p0, 2);
      if (pulse_q.size() >= 2)
         check("b2b_spacing", pulse_q[pulse_q.size()-1] - pulse_q[pulse_q.size()-2], NBITS * B);

      // Reset in the middle of data bit 3 of 0x55, then a clean 0x31
      p0 = pulses;
      r = 8'h55;
      drive_bit(1'b0);
      for (int i = 0; i < 3; i++) drive_bit(r[i]);
      RXD = r[3];
      idle(H);
      RST = 1'b1;
      idle(3);
      RXD = 1'b1;
      RST = 1'b0;
      idle(1);
      check("midrst_data", 32'(RX_DATA_R), 32'h000);
      idle(12 * B);
      check("midrst_no_pulse", pulses - p0, 0);
      check("midrst_state", 32'(dut.state_q), 32'(ST_IDLE));
      send_frame(8'h31, good_par(8'h31), 1'b1, 1'b1, 10'h031);
      idle(2 * B);
      check("midrst_one_pulse", pulses - p0, 1);

      // Line low across reset release must not start a frame
      p0 = pulses;
      RXD = 1'b0;
      RST = 1'b1;
      idle(3);
      RST = 1'b0;
      idle(3 * B);
      check("lowline_no_pulse", pulses - p0, 0);
      check("lowline_state", 32'(dut.state_q), 32'(ST_IDLE));
      RXD = 1'b1;
      idle(2 * B);

      // A few random bytes
      for (int k = 0; k < 3; k++) begin
         r = 8'($urandom_range(0, 255));
         send_frame(r, good_par(r), 1'b1, 1'b1, {2'b00, r});
         idle($urandom_range(0, 3));
      end

      n = 0;
      while (sb.size() != 0 && n < 2000) begin
         @(posedge CLK);
         n++;
      end
      #1;
      check("scoreboard_drained", sb.size(), 0);
      check("hold_and_pulse_width", hold_viol, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
